mips_multicycle_control: RTL
============================

# mips_multicycle_control

Main control state machine for the multi-cycle MIPS core. It decodes the instruction opcode and sequences the shared datapath across cycles: the single memory port, the register file, and the single ALU. For the ALU it drives the 3-bit `alu_op` consumed by the ALU control unit. It also sequences PC update and register write-back, and stalls on a memory-ready handshake.

## Interface
Parameters:
- none; the opcode and `alu_op` encodings are fixed constants in the shared package.

Ports:
- `clk` in 1: single clock; every state change occurs on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: IR[31:26]; must be sampled only in DECODE.
- `zero` in 1: ALU zero flag; valid in BRANCH.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load qualified by `zero` in the datapath.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` out 1 and `mem_write` out 1: memory strobes, held until `mem_ready`.
- `ir_write` out 1: IR load.
- `mem_to_reg` out 1: write-back source; 1 = MDR, 0 = ALUOut.
- `reg_dst` out 1: destination register select; 1 = rd, 0 = rt.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = register A.
- `alu_src_b` out 2: ALU B select; 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op` out 3: 000 = add, 001 = sub, 011 = and, 100 = R-type (funct decides).
- `pc_source` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP.
- FETCH:
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=000, `pc_source`=00.
  - `ir_write` and `pc_write` assert only in a cycle where `mem_ready`=1; the FSM advances to DECODE in that same cycle.
  - Otherwise the FSM stays in FETCH.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=000 to compute the branch target.
  - Next state by opcode: lw/sw → MEM_ADDR; R-type → EXEC_R; addi/andi → EXEC_I; beq → BRANCH; j → JUMP.
  - Any other opcode: pulse `illegal_op` and return to FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `i_or_d`=1. Waits for `mem_ready`, then → MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Next state FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1. `instr_done`=1 in the cycle `mem_ready`=1, then → FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=100. Next state R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Next state FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000 for addi, 011 for andi. Next state I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Next state FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1. Next state FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `instr_done`=1. Next state FETCH.
- Opcode storage: addi vs andi is latched from `opcode` in DECODE into a 1-bit register. `opcode` is not re-read after DECODE.
- Unlisted outputs: 0 in every state.
- Mutual exclusion: `mem_read` and `mem_write` are never both 1; `reg_write` and any memory strobe are never both 1.

## Timing
- Output style: Moore decode of the registered state. The only Mealy terms are `mem_ready` gating of `ir_write`, `pc_write` and `instr_done`, and the `illegal_op` decode.
- Reset: while `rst`=1, every output is forced to 0 (including `alu_op`=000). The state register loads FETCH on the next edge. The first fetch strobe appears the cycle after `rst` deasserts.
- Reset mid-instruction: the instruction is abandoned with no write. `reg_write`/`mem_write` never assert in the reset cycle.
- Latency with `mem_ready` tied to 1:
  - lw: 5 cycles.
  - sw, R-type, addi, andi: 4 cycles.
  - beq, j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Memory wait states: each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle. All outputs are held stable during the wait.
- `instr_done`: exactly one pulse per completed instruction, never for an illegal opcode.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum;
  - the opcode constants;
  - the `alu_op` constants (ADD 000, SUB 001, AND 011, RTYPE 100), shared with the ALU control unit;
  - the `alu_src_b` and `pc_source` encodings.
- One sub-module: `mips_opcode_class`, a combinational opcode-to-class decoder with one-hot class outputs and `illegal`. The FSM lives in the top module.

## Test plan
- Reset, `mem_ready`=1: hold `rst`=1 for 3 cycles → all outputs 0. Release → next cycle FETCH with `mem_read`=1, `alu_src_b`=01, `ir_write`=1, `pc_write`=1.
- R-type (`opcode`=000000): EXEC_R shows `alu_op`=100. `instr_done` and `reg_write`/`reg_dst`=1 appear on cycle 4.
- lw with `mem_ready`=0 for 2 cycles in MEM_RD: outputs held stable through the wait. `instr_done` appears on cycle 7.
- beq: BRANCH shows `alu_op`=001, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1 on cycle 3. andi: EXEC_I shows `alu_op`=011.
- `opcode`=111111: `illegal_op` pulses in DECODE, no `instr_done`, next state FETCH. Separately, `rst` asserted in MEM_WR → `mem_write`=0 that cycle, then restart at FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes,
// ALU/mux select codes and the bundled control-word type.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_BRANCH,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    // Shared with the ALU control unit.
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_RTYPE = 3'b100;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic op_rtype;
        logic op_lw;
        logic op_sw;
        logic op_beq;
        logic op_j;
        logic op_addi;
        logic op_andi;
        logic illegal;
    } op_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctl_t;

endpackage

// File: rtl/mips_multicycle_control_opcode_class.sv
// Combinational opcode classifier: one-hot instruction class plus an
// illegal flag when no supported opcode matches.
module mips_opcode_class
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  cls
);

    // Entry order matches the hit[] bit assignment below.
    localparam logic [6:0][5:0] OPCODE_TABLE = {
        OP_ANDI, OP_ADDI, OP_J, OP_BEQ, OP_SW, OP_LW, OP_RTYPE
    };

    logic [6:0] hit;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_match
            assign hit[gi] = (opcode == OPCODE_TABLE[gi]);
        end
    endgenerate

    assign cls.op_rtype = hit[0];
    assign cls.op_lw    = hit[1];
    assign cls.op_sw    = hit[2];
    assign cls.op_beq   = hit[3];
    assign cls.op_j     = hit[4];
    assign cls.op_addi  = hit[5];
    assign cls.op_andi  = hit[6];
    assign cls.illegal  = ~|hit;

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences the shared memory
// port, register file and ALU, stalling on mem_ready.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t    state_reg, state_next;
    logic      is_andi_reg, is_store_reg;
    op_class_t cls;
    ctl_t      ctl;

    // The branch decision is made in the datapath; zero is only passed through there.
    logic unused_zero;
    assign unused_zero = zero;

    mips_opcode_class u_opcode_class (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            is_andi_reg  <= 1'b0;
            is_store_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Only the bits needed after DECODE are kept; opcode is not read again.
            if (state_reg == S_DECODE) begin
                is_andi_reg  <= cls.op_andi;
                is_store_reg <= cls.op_sw;
            end
        end
    end

    always_comb begin
        ctl        = '0;
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALU_ADD;
                ctl.pc_source = PCSRC_ALU;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.alu_src_b = SRCB_IMM_SH2;
                ctl.alu_op    = ALU_ADD;
                if (cls.op_lw || cls.op_sw) begin
                    state_next = S_MEM_ADDR;
                end else if (cls.op_rtype) begin
                    state_next = S_EXEC_R;
                end else if (cls.op_addi || cls.op_andi) begin
                    state_next = S_EXEC_I;
                end else if (cls.op_beq) begin
                    state_next = S_BRANCH;
                end else if (cls.op_j) begin
                    state_next = S_JUMP;
                end else begin
                    ctl.illegal_op = 1'b1;
                    state_next     = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_ADD;
                state_next    = is_store_reg ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                if (mem_ready) begin
                    ctl.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end
            end
            S_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_REG;
                ctl.alu_op    = ALU_RTYPE;
                state_next    = S_R_WB;
            end
            S_R_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b1;
                ctl.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = is_andi_reg ? ALU_AND : ALU_ADD;
                state_next    = S_I_WB;
            end
            S_I_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_REG;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
                ctl.instr_done    = 1'b1;
                state_next        = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PCSRC_JUMP;
                ctl.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
        // Reset silences every strobe immediately, so an abandoned store never writes.
        if (rst) begin
            ctl = '0;
        end
    end

    assign pc_write      = ctl.pc_write;
    assign pc_write_cond = ctl.pc_write_cond;
    assign i_or_d        = ctl.i_or_d;
    assign mem_read      = ctl.mem_read;
    assign mem_write     = ctl.mem_write;
    assign ir_write      = ctl.ir_write;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign reg_dst       = ctl.reg_dst;
    assign reg_write     = ctl.reg_write;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign alu_op        = ctl.alu_op;
    assign pc_source     = ctl.pc_source;
    assign instr_done    = ctl.instr_done;
    assign illegal_op    = ctl.illegal_op;

endmodule
